// File: rtl/spart_rx_if.sv
// rtl/spart_rx_if.sv - SPART receiver bus-side read interface (byte, status flags, read strobe)
interface spart_rx_if #(
  parameter int DATA_W = 8
) ();

  logic              rx_rd;
  logic [DATA_W-1:0] rx_data;
  logic              rda;
  logic              framing_err;
  logic              overrun;
  logic              parity_err;

  // Bus interface side: issues read strobes, observes byte and flags
  modport master (
    output rx_rd,
    input  rx_data,
    input  rda,
    input  framing_err,
    input  overrun,
    input  parity_err
  );

  // Receiver side: consumes read strobes, presents byte and flags
  modport slave (
    input  rx_rd,
    output rx_data,
    output rda,
    output framing_err,
    output overrun,
    output parity_err
  );

endinterface

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 serial receiver, 16x oversampled; SPART_RX_PARITY_EN adds even parity (8E1)
module spart_rx #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  spart_rx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

`ifdef SPART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] data_q;
  logic              rda_q;
  logic              framing_q;
  logic              overrun_q;
`ifdef SPART_RX_PARITY_EN
  logic              par_bit;
  logic              parity_q;
`endif

  logic rxd_meta;
  logic rxd_sync;
  logic rxd_prev;
  logic fall;

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // A held-low line never looks like a fresh edge, so it cannot retrigger
  assign fall = rxd_prev & ~rxd_sync;

  // Frame FSM, shift register and bus-visible status, all registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data_q    <= '0;
      rda_q     <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_bit   <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      // A read only consumes when a byte is present; accept below overrides it
      if (bus.rx_rd && rda_q) begin
        rda_q     <= 1'b0;
        overrun_q <= 1'b0;
        framing_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
        parity_q  <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (enable) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              // Line back high at mid start bit means a glitch, not a frame
              state    <= rxd_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (enable) begin
            if (tick_cnt == FULL_TICK) begin
              tick_cnt <= '0;
              shift    <= {rxd_sync, shift[DATA_W-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef SPART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef SPART_RX_PARITY_EN
        PARITY: begin
          if (enable) begin
            if (tick_cnt == FULL_TICK) begin
              tick_cnt <= '0;
              par_bit  <= rxd_sync;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (enable) begin
            if (tick_cnt == FULL_TICK) begin
              tick_cnt <= '0;
              // Back to IDLE at mid-stop so a start edge in the second half is caught
              state    <= IDLE;
              if (rxd_sync) begin
                data_q    <= shift;
                rda_q     <= 1'b1;
                framing_q <= 1'b0;
                if (rda_q && !bus.rx_rd) begin
                  overrun_q <= 1'b1;
                end
`ifdef SPART_RX_PARITY_EN
                parity_q  <= (^shift) != par_bit;
`endif
              end else begin
                framing_q <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rda         = rda_q;
  assign bus.framing_err = framing_q;
  assign bus.overrun     = overrun_q;
`ifdef SPART_RX_PARITY_EN
  assign bus.parity_err  = parity_q;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - scoreboard bench for spart_rx (enable every 4 clk, 64 clk per bit)
`timescale 1ns/1ps
module tb_spart_rx;

  localparam int BIT = 64;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    logic       perr;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;
  logic rxd    = 1'b1;

  spart_rx_if #(.DATA_W(8)) bus_if ();

  spart_rx dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rxd    (rxd),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int   phase = 0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  int   frame_start_cyc = 0;
  int   accept_cyc      = 0;
  int   lat_d           = 0;
  event start_ev;

  logic       rda_prev  = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic       en_prev   = 1'b0;

  // Baud tick: one clk high out of every four
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      phase  = (phase + 1) % 4;
      enable = (phase == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic ovr, input logic perr);
    exp_t e;
    e.data = d;
    e.ovr  = ovr;
    e.perr = perr;
    sb.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic align();
    do begin
      @(posedge clk);
      #2;
    end while (phase != 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    align();
    frame_start_cyc = cyc;
    rxd = 1'b0;
    -> start_ev;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      hold(BIT);
    end
`ifdef SPART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    hold(BIT);
`endif
    rxd = stop;
    hold(BIT);
    rxd = 1'b1;
  endtask

  task automatic read_clear(input string tag);
    @(posedge clk);
    #2 bus_if.rx_rd = 1'b1;
    @(posedge clk);
    #2 bus_if.rx_rd = 1'b0;
    @(negedge clk);
    check({tag, "_rda"}, bus_if.rda, 1'b0);
    check({tag, "_ovr"}, bus_if.overrun, 1'b0);
    check({tag, "_fe"}, bus_if.framing_err, 1'b0);
    check({tag, "_perr"}, bus_if.parity_err, 1'b0);
  endtask

  // Scoreboard: every accepted byte pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus_if.rda && (!rda_prev || bus_if.rx_data != data_prev)) begin
      accept_cyc = cyc;
      check("sb_pending", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rx_data", bus_if.rx_data, e.data);
        check("overrun", bus_if.overrun, e.ovr);
        check("parity_err", bus_if.parity_err, e.perr);
        check("rda_one_clk_after_tick", en_prev, 1'b1);
      end
    end
    rda_prev  = bus_if.rda;
    data_prev = bus_if.rx_data;
    en_prev   = enable;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus_if.rx_rd = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", bus_if.rx_data, 8'h00);
    check("rst_rda", bus_if.rda, 1'b0);
    check("rst_fe", bus_if.framing_err, 1'b0);
    check("rst_ovr", bus_if.overrun, 1'b0);
    check("rst_perr", bus_if.parity_err, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    hold(20);

    // Plain frame, then read clears rda
    expect_byte(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    lat_d = accept_cyc - frame_start_cyc;
    check("accept_in_stop_bit", (lat_d > 9 * BIT) && (lat_d < 10 * BIT), 1'b1);
    read_clear("t1_read");

    // Short low glitch is rejected, then a real frame
    align();
    rxd = 1'b0;
    hold(20);
    rxd = 1'b1;
    hold(150);
    @(negedge clk);
    check("glitch_rda", bus_if.rda, 1'b0);
    check("glitch_fe", bus_if.framing_err, 1'b0);
    check("glitch_ovr", bus_if.overrun, 1'b0);
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    read_clear("t2_read");

    // Two bytes with no read: overrun
    expect_byte(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    expect_byte(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_rda", bus_if.rda, 1'b1);
    check("t3_ovr", bus_if.overrun, 1'b1);
    read_clear("t3_read");

    // Stop bit low: framing error, byte not delivered
    send_frame(8'h7E, 1'b0, 1'b0);
    hold(100);
    @(negedge clk);
    check("t4_fe", bus_if.framing_err, 1'b1);
    check("t4_rda", bus_if.rda, 1'b0);
    check("t4_rx_data_kept", bus_if.rx_data, 8'h22);
    expect_byte(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_fe_cleared", bus_if.framing_err, 1'b0);
    check("t4_rda_after", bus_if.rda, 1'b1);
    read_clear("t4_read");

    // Read strobe in the very clk the second byte is accepted
    expect_byte(8'h44, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    expect_byte(8'h55, 1'b0, 1'b0);
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        @(start_ev);
        repeat (lat_d - 1) @(posedge clk);
        #2 bus_if.rx_rd = 1'b1;
        @(posedge clk);
        #2 bus_if.rx_rd = 1'b0;
      end
    join
    @(negedge clk);
    check("t5_rda", bus_if.rda, 1'b1);
    check("t5_ovr", bus_if.overrun, 1'b0);
    check("t5_rx_data", bus_if.rx_data, 8'h55);

    // Leave a byte pending, then reset mid data bit 4
    expect_byte(8'h66, 1'b1, 1'b0);
    send_frame(8'h66, 1'b1, 1'b0);
    align();
    rxd = 1'b0;
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = 8'h5A >> i;
      hold(BIT);
    end
    rxd = 1'b1;
    hold(BIT / 2);
    #3 rst = 1'b0;
    #1;
    check("t6_rx_data", bus_if.rx_data, 8'h00);
    check("t6_rda", bus_if.rda, 1'b0);
    check("t6_fe", bus_if.framing_err, 1'b0);
    check("t6_ovr", bus_if.overrun, 1'b0);
    check("t6_perr", bus_if.parity_err, 1'b0);
    hold(3);
    rst = 1'b1;
    hold(200);
    @(negedge clk);
    check("t6_rda_after", bus_if.rda, 1'b0);
    check("t6_fe_after", bus_if.framing_err, 1'b0);

`ifdef SPART_RX_PARITY_EN
    // Wrong parity: byte still delivered with parity_err
    expect_byte(8'h03, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    read_clear("t6_par_read");
    expect_byte(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    read_clear("t6_par_ok_read");
`endif

    hold(50);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
